// File: rtl/note_sequencer_multi.sv
// Multi-voice note sequencer: CHANNELS voices walk their own songs from one shared
// synchronous note ROM through a round-robin, three-cycle fetch engine.
module note_sequencer_multi #(
    parameter int CHANNELS    = 2,
    parameter int ADDR_WIDTH  = 5,
    parameter int PITCH_WIDTH = 7,
    parameter int DUR_WIDTH   = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_note_stb,
    input  logic [CHANNELS-1:0]             i_restart,
    input  logic [CHANNELS-1:0]             i_loop,
    input  logic [CHANNELS*ADDR_WIDTH-1:0]  i_start_addr,
    output logic [ADDR_WIDTH-1:0]           o_rom_addr,
    input  logic [PITCH_WIDTH+DUR_WIDTH:0]  i_rom_data,
    output logic [CHANNELS*PITCH_WIDTH-1:0] o_pitch,
    output logic [CHANNELS-1:0]             o_gate,
    output logic [CHANNELS-1:0]             o_note_start,
    output logic [CHANNELS-1:0]             o_done
);
    localparam int DATA_WIDTH = 1 + PITCH_WIDTH + DUR_WIDTH;
    localparam int SEL_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {CH_LOAD, CH_PLAY, CH_DONE} ch_state_e;
    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_CAPTURE} fetch_state_e;

    ch_state_e              st_q    [CHANNELS];
    ch_state_e              st_d    [CHANNELS];
    logic [ADDR_WIDTH-1:0]  ptr_q   [CHANNELS];
    logic [ADDR_WIDTH-1:0]  ptr_d   [CHANNELS];
    logic [DUR_WIDTH-1:0]   cnt_q   [CHANNELS];
    logic [DUR_WIDTH-1:0]   cnt_d   [CHANNELS];
    logic [PITCH_WIDTH-1:0] pitch_q [CHANNELS];
    logic [PITCH_WIDTH-1:0] pitch_d [CHANNELS];
    logic [CHANNELS-1:0]    gate_q, gate_d;
    logic [CHANNELS-1:0]    done_q, done_d;
    logic [CHANNELS-1:0]    nstart_q, nstart_d;
    logic [CHANNELS-1:0]    prev_end_q, prev_end_d;

    fetch_state_e           fst_q, fst_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [SEL_WIDTH-1:0]   arb_q, arb_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

    logic [CHANNELS-1:0]    req;
    logic                   found;
    logic [SEL_WIDTH-1:0]   pick;
    logic [SEL_WIDTH-1:0]   cand;
    logic                   cap;

    logic                   rom_end;
    logic [PITCH_WIDTH-1:0] rom_pitch;
    logic [DUR_WIDTH-1:0]   rom_dur;

    assign rom_end   = i_rom_data[DATA_WIDTH-1];
    assign rom_pitch = i_rom_data[PITCH_WIDTH+DUR_WIDTH-1:DUR_WIDTH];
    assign rom_dur   = i_rom_data[DUR_WIDTH-1:0];

    // A channel being restarted this cycle is not eligible; its pointer is about to change.
    always_comb begin
        req   = '0;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < CHANNELS; k++)
            req[k] = (st_q[k] == CH_LOAD) && !i_restart[k];
        for (int i = 0; i < CHANNELS; i++) begin
            cand = SEL_WIDTH'((int'(arb_q) + i) % CHANNELS);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        fst_d  = fst_q;
        sel_d  = sel_q;
        arb_d  = arb_q;
        addr_d = addr_q;
        cap    = 1'b0;
        case (fst_q)
            F_IDLE: begin
                if (found) begin
                    sel_d  = pick;
                    addr_d = ptr_q[pick];
                    fst_d  = F_WAIT;
                end
            end
            F_WAIT: begin
                fst_d = i_restart[sel_q] ? F_IDLE : F_CAPTURE;
            end
            F_CAPTURE: begin
                fst_d = F_IDLE;
                if (!i_restart[sel_q]) begin
                    cap   = 1'b1;
                    arb_d = (int'(sel_q) == CHANNELS - 1) ? '0 : sel_q + SEL_WIDTH'(1);
                end
            end
            default: fst_d = F_IDLE;
        endcase
    end

    // Per-channel priority: restart, then capture of its own fetch, then the tempo strobe.
    always_comb begin
        st_d       = st_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        pitch_d    = pitch_q;
        gate_d     = gate_q;
        done_d     = done_q;
        prev_end_d = prev_end_q;
        nstart_d   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_restart[k]) begin
                ptr_d[k]      = i_start_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                done_d[k]     = 1'b0;
                gate_d[k]     = 1'b0;
                prev_end_d[k] = 1'b0;
                st_d[k]       = CH_LOAD;
            end else if (cap && (int'(sel_q) == k)) begin
                if (!rom_end) begin
                    pitch_d[k]    = rom_pitch;
                    ptr_d[k]      = ptr_q[k] + ADDR_WIDTH'(1);
                    cnt_d[k]      = (rom_dur == '0) ? DUR_WIDTH'(1) : rom_dur;
                    gate_d[k]     = (rom_pitch != '0);
                    nstart_d[k]   = 1'b1;
                    prev_end_d[k] = 1'b0;
                    st_d[k]       = CH_PLAY;
                end else if (i_loop[k] && !prev_end_q[k]) begin
                    ptr_d[k]      = i_start_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                    prev_end_d[k] = 1'b1;
                end else begin
                    st_d[k]       = CH_DONE;
                    done_d[k]     = 1'b1;
                    gate_d[k]     = 1'b0;
                    prev_end_d[k] = 1'b1;
                end
            end else if (i_note_stb && (st_q[k] == CH_PLAY)) begin
                if (cnt_q[k] == DUR_WIDTH'(1))
                    st_d[k] = CH_LOAD;
                else
                    cnt_d[k] = cnt_q[k] - DUR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fst_q      <= F_IDLE;
            sel_q      <= '0;
            arb_q      <= '0;
            addr_q     <= '0;
            gate_q     <= '0;
            done_q     <= '0;
            nstart_q   <= '0;
            prev_end_q <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                st_q[k]    <= CH_LOAD;
                ptr_q[k]   <= i_start_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                cnt_q[k]   <= '0;
                pitch_q[k] <= '0;
            end
        end else begin
            fst_q      <= fst_d;
            sel_q      <= sel_d;
            arb_q      <= arb_d;
            addr_q     <= addr_d;
            gate_q     <= gate_d;
            done_q     <= done_d;
            nstart_q   <= nstart_d;
            prev_end_q <= prev_end_d;
            st_q       <= st_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            pitch_q    <= pitch_d;
        end
    end

    always_comb begin
        o_pitch = '0;
        for (int k = 0; k < CHANNELS; k++)
            o_pitch[k*PITCH_WIDTH +: PITCH_WIDTH] = pitch_q[k];
    end

    assign o_rom_addr   = addr_q;
    assign o_gate       = gate_q;
    assign o_note_start = nstart_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_note_sequencer_multi.sv
// Directed bench for note_sequencer_multi at default parameters (2 channels, 16-bit entries).
module tb_note_sequencer_multi;
    logic        clk = 1'b0;
    logic        rst, stb;
    logic [1:0]  restart, loop;
    logic [9:0]  start_addr;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [13:0] pitch;
    logic [1:0]  gate, nstart, done;
    logic [15:0] rom [32];
    int          total = 0;
    int          bad   = 0;
    int          ns0   = 0;
    int          ns1   = 0;
    int          base0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(negedge clk) begin
        if (nstart[0]) ns0++;
        if (nstart[1]) ns1++;
    end

    note_sequencer_multi dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_note_stb   (stb),
        .i_restart    (restart),
        .i_loop       (loop),
        .i_start_addr (start_addr),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_pitch      (pitch),
        .o_gate       (gate),
        .o_note_start (nstart),
        .o_done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ent(input logic e, input int p, input int d);
        return {e, 7'(p), 8'(d)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        stb = 1'b1;
        step();
        stb = 1'b0;
    endtask

    task automatic setup(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] lp);
        for (int i = 0; i < 32; i++) rom[i] = 16'h8000;
        start_addr = {s1, s0};
        loop       = lp;
        restart    = 2'b00;
        stb        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; restart = 2'b00; loop = 2'b00; start_addr = '0;

        // single note, D=3
        setup(5'd0, 5'd16, 2'b00);
        rom[0] = ent(0, 10, 3);
        do_reset();
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_pitch", 32'(pitch), 0);
        chk("rst_gate", 32'(gate), 0);
        chk("rst_nstart", 32'(nstart), 0);
        chk("rst_done", 32'(done), 0);
        base0 = ns0;
        step();
        chk("t1_addr0", 32'(rom_addr), 0);
        step(); step();
        chk("t1_nstart", 32'(nstart), 32'h1);
        chk("t1_pitch", 32'(pitch[6:0]), 10);
        chk("t1_gate", 32'(gate[0]), 1);
        step();
        chk("t1_nstart_clr", 32'(nstart), 0);
        chk("t1_addr16", 32'(rom_addr), 16);
        step(); step();
        chk("t1_ch1_done", 32'(done), 32'h2);
        repeat (19) step(); strobe();
        repeat (19) step(); strobe();
        step();
        chk("t1_nofetch", 32'(rom_addr), 16);
        repeat (18) step(); strobe();
        chk("t1_gate_hold", 32'(gate[0]), 1);
        step();
        chk("t1_refetch", 32'(rom_addr), 1);
        step(); step();
        chk("t1_once", 32'(ns0 - base0), 1);

        // end without loop
        setup(5'd0, 5'd16, 2'b00);
        rom[0] = ent(0, 5, 1);
        do_reset();
        repeat (6) step();
        strobe();
        step();
        chk("t2_addr1", 32'(rom_addr), 1);
        step(); step();
        chk("t2_done", 32'(done), 32'h3);
        chk("t2_gate", 32'(gate[0]), 0);
        chk("t2_pitch", 32'(pitch[6:0]), 5);
        base0 = ns0;
        repeat (3) begin repeat (4) step(); strobe(); end
        repeat (4) step();
        chk("t2_idle_addr", 32'(rom_addr), 1);
        chk("t2_no_note", 32'(ns0 - base0), 0);
        chk("t2_done_hold", 32'(done), 32'h3);

        // loop mode
        setup(5'd0, 5'd16, 2'b01);
        rom[0] = ent(0, 5, 1);
        do_reset();
        repeat (6) step();
        strobe();
        step();
        chk("t3_addr1", 32'(rom_addr), 1);
        step(); step();
        chk("t3_notdone", 32'(done), 32'h2);
        chk("t3_gate_keep", 32'(gate[0]), 1);
        step();
        chk("t3_addr0", 32'(rom_addr), 0);
        step(); step();
        chk("t3_nstart", 32'(nstart), 32'h1);
        chk("t3_pitch", 32'(pitch[6:0]), 5);

        // empty looped song; also exercises the rotating arbiter
        setup(5'd2, 5'd16, 2'b01);
        do_reset();
        base0 = ns0;
        step();
        chk("t3e_addr2", 32'(rom_addr), 2);
        step(); step();
        chk("t3e_first", 32'(done), 0);
        step();
        chk("t3e_arb_ch1", 32'(rom_addr), 16);
        step(); step(); step();
        chk("t3e_addr2b", 32'(rom_addr), 2);
        step(); step();
        chk("t3e_done", 32'(done), 32'h3);
        chk("t3e_no_note", 32'(ns0 - base0), 0);

        // arbitration, both channels on the same strobe
        setup(5'd0, 5'd16, 2'b00);
        rom[0]  = ent(0, 3, 1);  rom[1]  = ent(0, 4, 1);  rom[2]  = ent(0, 6, 1);
        rom[16] = ent(0, 20, 1); rom[17] = ent(0, 21, 1); rom[18] = ent(0, 22, 1);
        do_reset();
        repeat (9) step();
        strobe();
        step();
        chk("t4_a_ch0", 32'(rom_addr), 1);
        step();
        chk("t4_a_hold", 32'(rom_addr), 1);
        step();
        chk("t4_a_pitch0", 32'(pitch[6:0]), 4);
        step();
        chk("t4_a_ch1", 32'(rom_addr), 17);
        step(); step();
        chk("t4_a_pitch1", 32'(pitch[13:7]), 21);
        repeat (3) step();
        strobe();
        step();
        chk("t4_b_ch0", 32'(rom_addr), 2);
        repeat (3) step();
        chk("t4_b_ch1", 32'(rom_addr), 18);

        // rest note and pointer wrap
        setup(5'd31, 5'd16, 2'b00);
        rom[31] = ent(0, 0, 1);
        rom[0]  = ent(0, 9, 1);
        do_reset();
        repeat (3) step();
        chk("t5_rest_nstart", 32'(nstart), 32'h1);
        chk("t5_rest_gate", 32'(gate[0]), 0);
        repeat (3) step();
        strobe();
        step();
        chk("t5_wrap", 32'(rom_addr), 0);
        step(); step();
        chk("t5_pitch", 32'(pitch[6:0]), 9);
        chk("t5_gate", 32'(gate[0]), 1);

        // restart during WAIT, then mid-song reset
        setup(5'd0, 5'd16, 2'b00);
        rom[0]  = ent(0, 10, 200);
        rom[16] = ent(0, 20, 1);
        rom[17] = ent(0, 21, 1);
        do_reset();
        repeat (8) step();
        strobe();
        step();
        chk("t6_addr17", 32'(rom_addr), 17);
        restart = 2'b10;
        step();
        restart = 2'b00;
        chk("t6_gate_clr", 32'(gate[1]), 0);
        step();
        chk("t6_addr16", 32'(rom_addr), 16);
        chk("t6_discard", 32'(pitch[13:7]), 20);
        chk("t6_no_nstart", 32'(nstart), 0);
        step(); step();
        chk("t6_nstart", 32'(nstart), 32'h2);
        chk("t6_gate1", 32'(gate[1]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_addr", 32'(rom_addr), 0);
        chk("t6_rst_pitch", 32'(pitch), 0);
        chk("t6_rst_gate", 32'(gate), 0);
        chk("t6_rst_nstart", 32'(nstart), 0);
        chk("t6_rst_done", 32'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
